fifo_burst_rd_ctrl: RTL and testbench
=====================================

FIFO_BURST_RD_CTRL -- requirements
Module: fifo_burst_rd_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- RD_DATA_WIDTH, 256, FIFO read word width and output data width.
- RD_DEPTH_WIDTH, 8, FIFO read-side depth width; water level is RD_DEPTH_WIDTH+1 bits.
- BURST_LEN, 16, words per full burst, 1..2**RD_DEPTH_WIDTH.
- ADDR_WIDTH, 28, byte address width.
- BASE_ADDR, 0, frame start byte address.
- FRAME_BURSTS, 64, full bursts per frame before address wrap.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock for all logic.
- tb_rst, in, 1, reset, asynchronous, active-high.
- fifo_rd_water_level, in, RD_DEPTH_WIDTH+1, FIFO words available.
- fifo_rd_empty, in, 1, FIFO empty.
- fifo_rd_data, in, RD_DATA_WIDTH, FIFO read data, valid 1 cycle after fifo_rd_en.
- fifo_rd_en, out, 1, FIFO pop.
- flush, in, 1, pulse: drain residual words as a short burst.
- cmd_valid, out, 1, burst command valid.
- cmd_ready, in, 1, burst command accepted.
- cmd_addr, out, ADDR_WIDTH, burst byte address.
- cmd_len, out, 8, burst length minus 1.
- wr_valid, out, 1, data beat valid.
- wr_ready, in, 1, data beat accepted.
- wr_data, out, RD_DATA_WIDTH, data beat.
- wr_last, out, 1, final beat of the burst.
- frame_done, out, 1, one-cycle pulse after the last burst of a frame completes.
- busy, out, 1, state != IDLE.

Function
REQ-003 FSM states SHALL be IDLE, CMD, DATA, DONE.
REQ-004 IDLE->CMD SHALL occur when fifo_rd_water_level >= BURST_LEN; burst length is then BURST_LEN.
REQ-005 Flush: when flush_pend is set, level < BURST_LEN and level > 0, IDLE->CMD SHALL occur with burst length = level, sampled that cycle.
REQ-006 flush_pend SHALL be set by flush in any state and cleared on entering CMD for a short burst, or in IDLE when level==0.
REQ-007 In CMD, cmd_valid SHALL be 1 with cmd_addr and cmd_len stable until cmd_ready; on handshake CMD->DATA.
REQ-008 In DATA, fifo_rd_en SHALL assert only when !fifo_rd_empty, pops issued < burst length, and (skid occupancy + pops in flight) < 2; fifo_rd_en SHALL never assert outside DATA.
REQ-009 Each popped word SHALL enter a 2-entry skid FIFO one cycle after fifo_rd_en; wr_valid = skid not empty; wr_data = skid head.
REQ-010 wr_last SHALL be 1 on the beat whose index == burst length-1.
REQ-011 A beat SHALL transfer on wr_valid&wr_ready; the transfer of the last beat causes DATA->DONE.
REQ-012 DONE SHALL last 1 cycle: advance the address, then go to IDLE.
REQ-013 Address: cmd_addr = BASE_ADDR + burst_offset; a full burst SHALL add BURST_LEN*RD_DATA_WIDTH/8 to the offset; a short burst SHALL add len*RD_DATA_WIDTH/8.
REQ-014 After FRAME_BURSTS full bursts, or after any short (flush) burst, the offset SHALL wrap to 0 and frame_done SHALL pulse in the DONE cycle.
REQ-015 Address arithmetic SHALL be modulo 2**ADDR_WIDTH.
REQ-016 The output stream SHALL be backpressure-safe: wr_ready low for N cycles SHALL lose and duplicate no word; beat order SHALL equal FIFO order.
REQ-017 flush arriving in CMD or DATA SHALL not truncate the current burst; it is honoured in the next IDLE.

Reset
REQ-018 On tb_rst: state=IDLE, offset=0, flush_pend=0, skid empty, counters=0; outputs fifo_rd_en, cmd_valid, wr_valid, wr_last, frame_done, busy=0; cmd_addr=BASE_ADDR; cmd_len=0; wr_data=0.
REQ-019 Reset mid-burst SHALL abandon the burst immediately, with no further beats or pops after release until a new IDLE->CMD.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, BEAT_BYTES = RD_DATA_WIDTH/8 and the cmd_len width (8).
REQ-021 The 2-entry skid buffer SHALL be a sub-module, skid_buf2, parameterised by data width.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Level 16, cmd_ready=1, wr_ready=1: one command with cmd_addr=BASE_ADDR and cmd_len=15; 16 beats; wr_last on beat 16; 16 pops total.
- Level 15 held, flush pulse: one command with cmd_len=14; 15 beats; frame_done pulses; next cmd_addr=BASE_ADDR.
- 64 consecutive full bursts: cmd_addr steps by 512 B; frame_done after burst 64; burst 65 addr=BASE_ADDR.
- wr_ready toggling 1-0-1-0 with a 3-cycle low: output data equals the FIFO sequence exactly; fifo_rd_en never asserts with skid full plus one pop in flight.
- cmd_ready delayed 5 cycles: cmd_addr and cmd_len stable; no fifo_rd_en before the handshake.
- tb_rst at beat 7 of 16: all outputs 0 within the reset; after release with level=0, no activity.

Source files
------------

// File: rtl/fifo_burst_rd_ctrl_pkg.sv
// Shared types and constants for the burst read controller.
// FSM states, beat sizing and command length width.
package fifo_burst_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  localparam int CMD_LEN_W = 8;
  localparam int RD_DATA_WIDTH_DEF = 256;

  function automatic int beat_bytes(input int w);
    return w / 8;
  endfunction

  localparam int BEAT_BYTES = beat_bytes(RD_DATA_WIDTH_DEF);

endpackage

// File: rtl/fifo_burst_rd_ctrl_skid_buf2.sv
// Two-entry skid FIFO between FIFO read data and the beat output.
// Push is never issued when full; pop is ignored when empty.
module skid_buf2 #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         tb_rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign valid  = (count != 2'd0);
  assign head   = mem[rd_ptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_rd_ctrl.sv
// Burst read controller: drains a FIFO into address/data bursts.
// Full bursts on water level, short bursts on a pending flush.
module fifo_burst_rd_ctrl
  import fifo_burst_rd_ctrl_pkg::*;
#(
  parameter int RD_DATA_WIDTH  = 256,
  parameter int RD_DEPTH_WIDTH = 8,
  parameter int BURST_LEN      = 16,
  parameter int ADDR_WIDTH     = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int FRAME_BURSTS   = 64
) (
  input  logic                     clk,
  input  logic                     tb_rst,
  input  logic [RD_DEPTH_WIDTH:0]  fifo_rd_water_level,
  input  logic                     fifo_rd_empty,
  input  logic [RD_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                     fifo_rd_en,
  input  logic                     flush,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_WIDTH-1:0]    cmd_addr,
  output logic [CMD_LEN_W-1:0]     cmd_len,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [RD_DATA_WIDTH-1:0] wr_data,
  output logic                     wr_last,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int BB   = beat_bytes(RD_DATA_WIDTH);
  localparam int LW   = RD_DEPTH_WIDTH + 1;
  localparam int CW   = CMD_LEN_W + 1;
  localparam int FB_W = $clog2(FRAME_BURSTS + 1);

  localparam logic [ADDR_WIDTH-1:0] FULL_STEP =
    ADDR_WIDTH'(BURST_LEN * BB);
  localparam logic [LW-1:0] BL_LVL = LW'(BURST_LEN);
  localparam logic [CMD_LEN_W-1:0] BL_M1 =
    CMD_LEN_W'(BURST_LEN - 1);
  localparam logic [FB_W-1:0] FB_LAST =
    FB_W'(FRAME_BURSTS - 1);

  state_t                 state;
  state_t                 state_n;
  logic                   flush_pend;
  logic                   flush_pend_n;
  logic [CMD_LEN_W-1:0]   len_m1;
  logic [CMD_LEN_W-1:0]   len_m1_n;
  logic                   short_b;
  logic                   short_b_n;
  logic [ADDR_WIDTH-1:0]  offset;
  logic [ADDR_WIDTH-1:0]  offset_n;
  logic [FB_W-1:0]        fb_cnt;
  logic [FB_W-1:0]        fb_cnt_n;
  logic [CW-1:0]          pop_cnt;
  logic [CW-1:0]          beat_cnt;
  logic [CW-1:0]          len_full;
  logic                   inflight;
  logic [1:0]             skid_cnt;
  logic                   beat;
  logic                   frame_wrap;

  assign len_full   = {1'b0, len_m1} + CW'(1);
  assign beat       = wr_valid && wr_ready;
  assign frame_wrap = short_b || (fb_cnt == FB_LAST);

  assign fifo_rd_en = (state == DATA) && !fifo_rd_empty
                   && (pop_cnt < len_full)
                   && ((skid_cnt + {1'b0, inflight}) < 2'd2);

  assign wr_last    = wr_valid && (beat_cnt == {1'b0, len_m1});
  assign cmd_valid  = (state == CMD);
  assign cmd_addr   = BASE_ADDR + offset;
  assign cmd_len    = len_m1;
  assign frame_done = (state == DONE) && frame_wrap;
  assign busy       = (state != IDLE);

  skid_buf2 #(
    .W(RD_DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .tb_rst    (tb_rst),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (beat),
    .valid     (wr_valid),
    .head      (wr_data),
    .count     (skid_cnt)
  );

  // next state, burst setup, flush tracking, address advance
  always_comb begin
    state_n      = state;
    flush_pend_n = flush_pend;
    len_m1_n     = len_m1;
    short_b_n    = short_b;
    offset_n     = offset;
    fb_cnt_n     = fb_cnt;
    unique case (state)
      IDLE: begin
        if (fifo_rd_water_level >= BL_LVL) begin
          state_n   = CMD;
          len_m1_n  = BL_M1;
          short_b_n = 1'b0;
        end else if (flush_pend
                  && (fifo_rd_water_level != '0)) begin
          state_n      = CMD;
          len_m1_n     = CMD_LEN_W'(fifo_rd_water_level
                                    - LW'(1));
          short_b_n    = 1'b1;
          flush_pend_n = 1'b0;
        end else if (fifo_rd_water_level == '0) begin
          flush_pend_n = 1'b0;
        end
      end
      CMD: begin
        if (cmd_ready) state_n = DATA;
      end
      DATA: begin
        if (beat && wr_last) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
        if (frame_wrap) begin
          offset_n = '0;
          fb_cnt_n = '0;
        end else begin
          offset_n = offset + FULL_STEP;
          fb_cnt_n = fb_cnt + FB_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) flush_pend_n = 1'b1;
  end

  // FSM and burst context registers
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      len_m1     <= '0;
      short_b    <= 1'b0;
      offset     <= '0;
      fb_cnt     <= '0;
      inflight   <= 1'b0;
    end else begin
      state      <= state_n;
      flush_pend <= flush_pend_n;
      len_m1     <= len_m1_n;
      short_b    <= short_b_n;
      offset     <= offset_n;
      fb_cnt     <= fb_cnt_n;
      inflight   <= fifo_rd_en;
    end
  end

  // per-burst pop and beat counters, cleared while commanding
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      pop_cnt  <= '0;
      beat_cnt <= '0;
    end else if (state == CMD) begin
      pop_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (fifo_rd_en) pop_cnt  <= pop_cnt + CW'(1);
      if (beat)       beat_cnt <= beat_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Bench for fifo_burst_rd_ctrl: FIFO model, beat scoreboard,
// burst vector table and reset / frame-wrap sequences.
module tb_fifo_burst_rd_ctrl;
  import fifo_burst_rd_ctrl_pkg::*;

  localparam int DW  = 256;
  localparam int DPW = 8;
  localparam int BL  = 16;
  localparam int AW  = 28;
  localparam int FB  = 64;
  localparam logic [AW-1:0] BASE = 28'h0010000;
  localparam int STEP = BL * BEAT_BYTES;
  localparam bit [5:0] PAT = 6'b000101;

  typedef struct {
    int n;
    int fl;
    int crd;
    int wm;
    int len;
    int off;
    int fd;
  } vec_t;

  logic           clk = 1'b0;
  logic           tb_rst;
  logic [DPW:0]   fifo_rd_water_level;
  logic           fifo_rd_empty;
  logic [DW-1:0]  fifo_rd_data = '0;
  logic           fifo_rd_en;
  logic           flush;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [AW-1:0]  cmd_addr;
  logic [7:0]     cmd_len;
  logic           wr_valid;
  logic           wr_ready;
  logic [DW-1:0]  wr_data;
  logic           wr_last;
  logic           frame_done;
  logic           busy;

  logic [DW-1:0]  fmem [0:2047];
  int wp = 0;
  int rp = 0;
  int sp = 0;
  int nvec = 0;
  int nerr = 0;
  int pops_done = 0;
  int beats_done = 0;
  int pop_burst = 0;
  int beat_idx = 0;
  int cur_len = 0;
  int exp_blen = 0;
  int fd_cnt = 0;
  bit in_data = 1'b0;

  fifo_burst_rd_ctrl #(
    .RD_DATA_WIDTH  (DW),
    .RD_DEPTH_WIDTH (DPW),
    .BURST_LEN      (BL),
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (BASE),
    .FRAME_BURSTS   (FB)
  ) dut (
    .clk                 (clk),
    .tb_rst              (tb_rst),
    .fifo_rd_water_level (fifo_rd_water_level),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_en          (fifo_rd_en),
    .flush               (flush),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_addr            (cmd_addr),
    .cmd_len             (cmd_len),
    .wr_valid            (wr_valid),
    .wr_ready            (wr_ready),
    .wr_data             (wr_data),
    .wr_last             (wr_last),
    .frame_done          (frame_done),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  assign fifo_rd_water_level = (DPW+1)'(wp - rp);
  assign fifo_rd_empty = (wp == rp);

  // FIFO model: one-cycle read latency, dropped on reset
  always @(posedge clk) begin
    if (tb_rst) begin
      rp <= wp;
    end else if (fifo_rd_en && (rp != wp)) begin
      fifo_rd_data <= fmem[rp];
      rp <= rp + 1;
    end
  end

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < DW/32; j++)
        w[j*32 +: 32] = $urandom;
      fmem[wp] = w;
      wp++;
    end
  endtask

  task automatic check_reset_outs;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_last", wr_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_addr", cmd_addr, BASE);
    chk("rst_cmd_len", cmd_len, 0);
    chk("rst_wr_data", wr_data, 0);
  endtask

  task automatic run_vec(input vec_t v, input int stop);
    int c;
    int fd0;
    int base;
    int nb;
    logic [AW-1:0] ea;
    fd0 = fd_cnt;
    ea = BASE + AW'(v.off);
    nb = (stop > 0) ? stop : v.len + 1;
    push_words(v.n);
    if (v.fl == 1) begin
      tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
    end
    c = 0;
    while (!cmd_valid && c < 200) begin
      tick;
      c++;
    end
    chk("cmd_seen", cmd_valid, 1);
    if (!cmd_valid) return;
    for (int i = 0; i <= v.crd; i++) begin
      chk("cmd_addr", cmd_addr, ea);
      chk("cmd_len", cmd_len, v.len);
      if (i < v.crd) tick;
    end
    exp_blen = v.len + 1;
    base = beats_done;
    cmd_ready = 1'b1;
    tick;
    cmd_ready = 1'b0;
    c = 0;
    while (beats_done < base + nb && c < 400) begin
      wr_ready = (v.wm == 1) ? PAT[c % 6] : 1'b1;
      flush = (v.fl == 2 && c == 2);
      tick;
      c++;
    end
    wr_ready = 1'b1;
    flush = 1'b0;
    chk("beat_count", beats_done - base, nb);
    if (stop > 0) return;
    repeat (3) tick;
    chk("frame_done", fd_cnt - fd0, v.fd);
  endtask

  // scoreboard and handshake monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (tb_rst) begin
        sp = wp;
        in_data = 1'b0;
        pops_done = beats_done;
      end else begin
        if (fifo_rd_en) begin
          chk("rd_en_in_data", in_data, 1);
          chk("rd_en_not_empty", wp != rp, 1);
          chk("rd_en_room", (pops_done - beats_done) < 2, 1);
          pops_done++;
          pop_burst++;
        end
        if (wr_valid) chk("wr_valid_in_data", in_data, 1);
        if (wr_valid && wr_ready) begin
          chk("wr_data", wr_data, fmem[sp]);
          sp++;
          chk("wr_last", wr_last, beat_idx == cur_len - 1);
          beat_idx++;
          beats_done++;
          if (beat_idx == cur_len) begin
            chk("pops_per_burst", pop_burst, cur_len);
            in_data = 1'b0;
          end
        end
        if (cmd_valid && cmd_ready) begin
          in_data = 1'b1;
          cur_len = exp_blen;
          beat_idx = 0;
          pop_burst = 0;
        end
        if (frame_done) fd_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    vec_t v;
    bit act;
    tbl[0] = '{16, 0, 0, 0, 15, 0,    0};
    tbl[1] = '{15, 1, 0, 0, 14, 512,  1};
    tbl[2] = '{16, 0, 5, 0, 15, 0,    0};
    tbl[3] = '{16, 0, 0, 1, 15, 512,  0};
    tbl[4] = '{20, 2, 0, 1, 15, 1024, 0};
    tbl[5] = '{0,  0, 3, 0, 3,  1536, 1};
    tbl[6] = '{3,  1, 2, 1, 2,  0,    1};
    tbl[7] = '{1,  1, 0, 0, 0,  0,    1};

    tb_rst = 1'b1;
    flush = 1'b0;
    cmd_ready = 1'b0;
    wr_ready = 1'b1;
    repeat (2) tick;
    check_reset_outs;
    tb_rst = 1'b0;
    tick;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], 0);

    for (int k = 0; k <= FB; k++) begin
      v = '{16, 0, 0, 0, 15, (k % FB) * STEP,
            (k == FB - 1) ? 1 : 0};
      run_vec(v, 0);
    end
    chk("idle_after_frame", busy, 0);

    v = '{16, 0, 0, 0, 15, FB * 0 + STEP, 0};
    run_vec(v, 7);
    tb_rst = 1'b1;
    @(negedge clk);
    check_reset_outs;
    repeat (3) tick;
    tb_rst = 1'b0;
    act = 1'b0;
    repeat (20) begin
      tick;
      if (cmd_valid || wr_valid || fifo_rd_en || busy)
        act = 1'b1;
    end
    chk("quiet_after_rst", act, 0);
    chk("level_after_rst", fifo_rd_water_level, 0);

    v = '{16, 0, 0, 0, 15, 0, 0};
    run_vec(v, 0);
    chk("idle_end", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
